// File: rtl/rtl_cnt_dn_lp.sv
// Loadable N-bit down-counter with borrow-in/out. Low K bits decrement directly;
// the high part swaps in a (hi-1) prediction resolved one bit per cycle.
module rtl_cnt_dn_lp #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [N-1:0] ld_val,
    input  logic         bin,
    output logic         rdy,
    output logic [N-1:0] counter,
    output logic         bout
);
    localparam int K      = $clog2(N);
    localparam int H      = N - K;
    localparam int SETTLE = H + 1;
    localparam int SW     = $clog2(SETTLE + 1);

    generate
        if (H + 1 > (1 << K)) begin : g_bad_width
            $error("rtl_cnt_dn_lp: N-K+1 must not exceed 2**K");
        end
    endgenerate

    logic [K-1:0]  lo_reg;
    logic [H-1:0]  hi_reg;
    logic [H-1:0]  pred_reg;
    logic [H-1:0]  pos_reg;
    logic          borrow_reg;
    logic          lo_zero_reg;
    logic          rdy_reg;
    logic          bout_reg;
    logic [SW-1:0] settle_reg;

    logic          dec;
    logic          lo_wrap;
    logic [K-1:0]  lo_next;
    logic [H-1:0]  pred_next;
    logic          borrow_next;

    assign dec     = bin & rdy_reg & ~ld;
    assign lo_wrap = dec & lo_zero_reg;
    assign lo_next = lo_reg - K'(1);

    // pos_reg marks the bit being resolved; a set hi bit there absorbs the borrow.
    // Once the borrow is absorbed nothing changes, so a borrow still pending after
    // the scan means hi was zero, which is exactly when a full wrap occurs.
    genvar gi;
    generate
        for (gi = 0; gi < H; gi++) begin : g_ripple
            assign pred_next[gi] = pred_reg[gi] ^ (pos_reg[gi] & borrow_reg);
        end
    endgenerate
    assign borrow_next = borrow_reg & ~|(pos_reg & pred_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            lo_reg      <= '0;
            hi_reg      <= '0;
            pred_reg    <= '1;
            pos_reg     <= '0;
            borrow_reg  <= 1'b1;
            lo_zero_reg <= 1'b1;
            rdy_reg     <= 1'b1;
            bout_reg    <= 1'b0;
            settle_reg  <= '0;
        end else if (ld) begin
            lo_reg      <= ld_val[K-1:0];
            hi_reg      <= ld_val[N-1:K];
            pred_reg    <= ld_val[N-1:K];
            pos_reg     <= H'(1);
            borrow_reg  <= 1'b1;
            lo_zero_reg <= (ld_val[K-1:0] == '0);
            rdy_reg     <= 1'b0;
            bout_reg    <= 1'b0;
            settle_reg  <= SW'(SETTLE);
        end else begin
            bout_reg <= lo_wrap & borrow_reg;
            if (settle_reg != '0) begin
                settle_reg <= settle_reg - SW'(1);
                rdy_reg    <= (settle_reg == SW'(1));
            end
            if (dec) begin
                lo_reg      <= lo_next;
                lo_zero_reg <= (lo_next == '0);
            end
            if (lo_wrap) begin
                hi_reg     <= pred_reg;
                pred_reg   <= pred_reg;
                pos_reg    <= H'(1);
                borrow_reg <= 1'b1;
            end else begin
                pred_reg   <= pred_next;
                pos_reg    <= pos_reg << 1;
                borrow_reg <= borrow_next;
            end
        end
    end

    assign counter = {hi_reg, lo_reg};
    assign rdy     = rdy_reg;
    assign bout    = bout_reg;
endmodule

// File: tb/tb_rtl_cnt_dn_lp.sv
// Bench for rtl_cnt_dn_lp: directed N=8 sequences plus randomized N=8/N=64 traffic
// checked every cycle against an arithmetic model of the counter.
module tb_rtl_cnt_dn_lp;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst8, ld8, bin8, rdy8, bout8;
    logic [7:0]  ldv8, cnt8;
    logic        rst64, ld64, bin64, rdy64, bout64;
    logic [63:0] ldv64, cnt64;

    rtl_cnt_dn_lp #(.N(8)) dut8 (
        .clk(clk), .rst(rst8), .ld(ld8), .ld_val(ldv8), .bin(bin8),
        .rdy(rdy8), .counter(cnt8), .bout(bout8)
    );
    rtl_cnt_dn_lp #(.N(64)) dut64 (
        .clk(clk), .rst(rst64), .ld(ld64), .ld_val(ldv64), .bin(bin64),
        .rdy(rdy64), .counter(cnt64), .bout(bout64)
    );

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: count, remaining settle cycles (rdy = none left), bout pulse.
    logic [7:0]  m8_cnt;
    int          m8_settle;
    bit          m8_bout;
    logic [63:0] m64_cnt;
    int          m64_settle;
    bit          m64_bout;

    always @(posedge clk) begin
        if (rst8) begin
            m8_cnt <= 8'd0; m8_settle <= 0; m8_bout <= 1'b0;
        end else if (ld8) begin
            m8_cnt <= ldv8; m8_settle <= 6; m8_bout <= 1'b0;
        end else begin
            if (m8_settle > 0) m8_settle <= m8_settle - 1;
            if (m8_settle == 0 && bin8) begin
                m8_cnt  <= m8_cnt - 8'd1;
                m8_bout <= (m8_cnt == 8'd0);
            end else begin
                m8_bout <= 1'b0;
            end
        end
        if (rst64) begin
            m64_cnt <= 64'd0; m64_settle <= 0; m64_bout <= 1'b0;
        end else if (ld64) begin
            m64_cnt <= ldv64; m64_settle <= 59; m64_bout <= 1'b0;
        end else begin
            if (m64_settle > 0) m64_settle <= m64_settle - 1;
            if (m64_settle == 0 && bin64) begin
                m64_cnt  <= m64_cnt - 64'd1;
                m64_bout <= (m64_cnt == 64'd0);
            end else begin
                m64_bout <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cnt8", 64'(cnt8), 64'(m8_cnt));
            check("rdy8", 64'(rdy8), 64'(m8_settle == 0));
            check("bout8", 64'(bout8), 64'(m8_bout));
            check("cnt64", cnt64, m64_cnt);
            check("rdy64", 64'(rdy64), 64'(m64_settle == 0));
            check("bout64", 64'(bout64), 64'(m64_bout));
        end
    end

    int bouts;
    logic [63:0] v;

    initial begin
        rst8 = 1'b1; ld8 = 1'b0; bin8 = 1'b0; ldv8 = '0;
        rst64 = 1'b1; ld64 = 1'b0; bin64 = 1'b0; ldv64 = '0;
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        check("reset_cnt", 64'(cnt8), 64'd0);
        check("reset_rdy", 64'(rdy8), 64'd1);
        check("reset_bout", 64'(bout8), 64'd0);

        // 1: release with bin held, wrap immediately
        rst8 = 1'b0; rst64 = 1'b0; bin8 = 1'b1;
        @(negedge clk); check("t1_wrap_cnt", 64'(cnt8), 64'd255); check("t1_wrap_bout", 64'(bout8), 64'd1);
        @(negedge clk); check("t1_cnt254", 64'(cnt8), 64'd254); check("t1_bout0", 64'(bout8), 64'd0);
        @(negedge clk); check("t1_cnt253", 64'(cnt8), 64'd253);
        $display("txn t1 done cnt8=%0d", cnt8);

        // 2: load 0x10 with bin held
        ld8 = 1'b1; ldv8 = 8'h10;
        @(negedge clk); ld8 = 1'b0;
        check("t2_ld_cnt", 64'(cnt8), 64'd16); check("t2_ld_rdy", 64'(rdy8), 64'd0);
        repeat (5) @(negedge clk);
        check("t2_settle_rdy", 64'(rdy8), 64'd0); check("t2_settle_cnt", 64'(cnt8), 64'd16);
        @(negedge clk); check("t2_rdy_up", 64'(rdy8), 64'd1); check("t2_hold16", 64'(cnt8), 64'd16);
        @(negedge clk); check("t2_cnt15", 64'(cnt8), 64'd15);
        repeat (8) @(negedge clk); check("t2_cnt7", 64'(cnt8), 64'd7);
        bin8 = 1'b0;
        $display("txn t2 done cnt8=%0d", cnt8);

        // 3: load 1, settle, three decrements
        ld8 = 1'b1; ldv8 = 8'h01;
        @(negedge clk); ld8 = 1'b0;
        repeat (6) @(negedge clk);
        check("t3_settled", 64'(rdy8), 64'd1); check("t3_cnt1", 64'(cnt8), 64'd1);
        bin8 = 1'b1; bouts = 0;
        @(negedge clk); bouts += int'(bout8); check("t3_cnt0", 64'(cnt8), 64'd0);
        @(negedge clk); bouts += int'(bout8); check("t3_cnt255", 64'(cnt8), 64'd255);
        @(negedge clk); bouts += int'(bout8); check("t3_cnt254", 64'(cnt8), 64'd254);
        bin8 = 1'b0;
        check("t3_one_bout", 64'(bouts), 64'd1);
        $display("txn t3 done bouts=%0d", bouts);

        // 4: load collides with bin; reload mid-settle restarts settle
        ld8 = 1'b1; ldv8 = 8'd50;
        @(negedge clk); ld8 = 1'b0;
        repeat (6) @(negedge clk);
        ld8 = 1'b1; ldv8 = 8'd9; bin8 = 1'b1;
        @(negedge clk); ld8 = 1'b0;
        check("t4_ld_wins", 64'(cnt8), 64'd9); check("t4_no_bout", 64'(bout8), 64'd0);
        repeat (2) @(negedge clk);
        ld8 = 1'b1; ldv8 = 8'd20;
        @(negedge clk); ld8 = 1'b0;
        repeat (5) @(negedge clk);
        check("t4_restart_rdy", 64'(rdy8), 64'd0); check("t4_restart_cnt", 64'(cnt8), 64'd20);
        @(negedge clk); check("t4_rdy_up", 64'(rdy8), 64'd1);
        @(negedge clk); check("t4_cnt19", 64'(cnt8), 64'd19);
        $display("txn t4 done cnt8=%0d", cnt8);

        // 5: reset mid-settle and mid-count
        ld8 = 1'b1; ldv8 = 8'd100;
        @(negedge clk); ld8 = 1'b0;
        repeat (2) @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk); rst8 = 1'b0;
        check("t5a_cnt", 64'(cnt8), 64'd0); check("t5a_rdy", 64'(rdy8), 64'd1); check("t5a_bout", 64'(bout8), 64'd0);
        repeat (3) @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk); rst8 = 1'b0;
        check("t5b_cnt", 64'(cnt8), 64'd0); check("t5b_rdy", 64'(rdy8), 64'd1); check("t5b_bout", 64'(bout8), 64'd0);
        $display("txn t5 done cnt8=%0d", cnt8);

        // 6: full 64-bit wrap from a load of zero
        ld64 = 1'b1; ldv64 = 64'd0;
        @(negedge clk); ld64 = 1'b0; bin64 = 1'b1;
        repeat (60) @(negedge clk);
        check("t6_full_wrap", cnt64, 64'hFFFF_FFFF_FFFF_FFFF);
        check("t6_full_bout", 64'(bout64), 64'd1);
        $display("txn t6 wrap cnt64=%0h", cnt64);

        // Randomized traffic on both widths
        for (int i = 0; i < 4000; i++) begin
            rst8  = ($urandom_range(0, 399) == 0);
            rst64 = ($urandom_range(0, 399) == 0);
            bin8  = ($urandom_range(0, 7) != 0);
            bin64 = ($urandom_range(0, 7) != 0);
            ld8   = ($urandom_range(0, 63) == 0);
            ldv8  = 8'($urandom);
            ld64  = ($urandom_range(0, 99) == 0);
            case ($urandom_range(0, 3))
                0: v = {32'($urandom), 32'($urandom)};
                1: v = ({32'($urandom), 32'($urandom)} & ~64'h3F) | 64'($urandom_range(0, 3));
                2: v = (64'd1 << $urandom_range(6, 63)) | 64'($urandom_range(0, 3));
                default: v = 64'($urandom_range(0, 3));
            endcase
            ldv64 = v;
            @(negedge clk);
            if (ld64) $display("txn rand ld64=%0h cnt64=%0h", ldv64, cnt64);
        end
        rst8 = 1'b0; rst64 = 1'b0; ld8 = 1'b0; ld64 = 1'b0; bin8 = 1'b0; bin64 = 1'b0;
        @(negedge clk);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
